// File: rtl/puf_soc_mux_sweep.sv
// Sequencer for the PUF response mux: steps the select through every slot and samples each one.
// Latency: start to o_valid takes 1 + MUX_SZ*(S+1) cycles, where S is the settle count latched at start.
// No backpressure: o_valid is a 1-cycle pulse; i_start is ignored while busy, and i_abort drops the sweep.
module puf_soc_mux_sweep #(
  parameter int N_BIT  = 1,
  parameter int MUX_SZ = 16,
  parameter int CNT_W  = 8,
  parameter int SEL_W  = $clog2(MUX_SZ)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic [CNT_W-1:0]        i_settle_cyc,
  input  logic [N_BIT-1:0]        i_mux_data,
  output logic [SEL_W-1:0]        o_sel_mux,
  output logic [MUX_SZ*N_BIT-1:0] o_resp,
  output logic                    o_valid,
  output logic                    o_busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(MUX_SZ - 1);

  logic [1:0]              state;
  logic [SEL_W-1:0]        sel;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        settle_lat;
  logic [MUX_SZ*N_BIT-1:0] shadow;
  logic [MUX_SZ*N_BIT-1:0] shadow_nxt;
  logic [MUX_SZ*N_BIT-1:0] resp;
  logic                    valid;

  // Shadow word with the current slot replaced by the mux output, so the last
  // sample can be published to o_resp on the same edge that captures it.
  always_comb begin
    shadow_nxt = shadow;
    shadow_nxt[sel*N_BIT +: N_BIT] = i_mux_data;
  end

  // Sweep FSM: settle countdown, per-slot sampling, atomic publish of the word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      sel        <= '0;
      cnt        <= '0;
      settle_lat <= '0;
      shadow     <= '0;
      resp       <= '0;
      valid      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          valid <= 1'b0;
          if (i_start && !i_abort) begin
            settle_lat <= i_settle_cyc;
            sel        <= '0;
            shadow     <= '0;
            if (i_settle_cyc != '0) begin
              cnt   <= i_settle_cyc;
              state <= ST_SETTLE;
            end else begin
              state <= ST_SAMPLE;
            end
          end
        end
        ST_SETTLE: begin
          if (i_abort) begin
            state  <= ST_IDLE;
            sel    <= '0;
            shadow <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
            // cnt starts at S, so the state lasts exactly S cycles.
            if (cnt == CNT_W'(1)) begin
              state <= ST_SAMPLE;
            end
          end
        end
        ST_SAMPLE: begin
          if (i_abort) begin
            state  <= ST_IDLE;
            sel    <= '0;
            shadow <= '0;
          end else begin
            shadow <= shadow_nxt;
            if (sel == SEL_LAST) begin
              // The whole word goes out in one go together with the valid pulse.
              resp  <= shadow_nxt;
              valid <= 1'b1;
              sel   <= '0;
              state <= ST_DONE;
            end else begin
              sel <= sel + SEL_W'(1);
              if (settle_lat != '0) begin
                cnt   <= settle_lat;
                state <= ST_SETTLE;
              end else begin
                state <= ST_SAMPLE;
              end
            end
          end
        end
        ST_DONE: begin
          // Abort is deliberately ignored here; the word is already published.
          valid <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          valid <= 1'b0;
          sel   <= '0;
        end
      endcase
    end
  end

  // Outputs are direct register/state decodes.
  always_comb begin
    o_sel_mux = sel;
    o_resp    = resp;
    o_valid   = valid;
    o_busy    = (state != ST_IDLE);
  end

endmodule

// File: tb/tb_puf_soc_mux_sweep.sv
// Bench for puf_soc_mux_sweep: table of sweeps, a reset-mid-sweep sequence, then random sweeps.
// A simple 16:1 mux model drives i_mux_data from the word under test.
// Expected results come from the vector table or the sweep-level reference model.
module tb_puf_soc_mux_sweep;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_start;
  logic        i_abort;
  logic [7:0]  i_settle_cyc;
  logic [0:0]  i_mux_data;
  logic [3:0]  o_sel_mux;
  logic [15:0] o_resp;
  logic        o_valid;
  logic        o_busy;

  logic [15:0] mux_word;
  logic [15:0] last_resp;

  int total;
  int bad;

  typedef struct {
    logic [15:0] word;
    int          s;
    int          abort_at;
    bit          extra;
    logic [15:0] exp_resp;
    int          exp_cyc;
  } vec_t;

  vec_t tbl[9];

  puf_soc_mux_sweep #(.N_BIT(1), .MUX_SZ(16), .CNT_W(8)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .i_settle_cyc(i_settle_cyc),
    .i_mux_data  (i_mux_data),
    .o_sel_mux   (o_sel_mux),
    .o_resp      (o_resp),
    .o_valid     (o_valid),
    .o_busy      (o_busy)
  );

  // Behavioural 16:1 mux: input k carries bit k of the word under test.
  assign i_mux_data = mux_word[o_sel_mux];

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One sweep; cycle 1 is the cycle right after the edge that accepts start.
  task automatic run_sweep(input vec_t v, input string nm);
    int cyc;
    int lim;
    bit got;
    bit busy_ok;
    bit sel_ok;
    bit idle_ok;
    mux_word = v.word;
    got = 0; busy_ok = 1; sel_ok = 1; idle_ok = 1;
    lim = (v.abort_at > 0) ? v.abort_at + 1 : 2000;
    i_settle_cyc = 8'(v.s);
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    cyc = 1;
    while (!got && cyc < lim) begin
      if (o_valid === 1'b1) begin
        got = 1;
      end else begin
        if (o_busy !== 1'b1) busy_ok = 0;
        if (cyc <= 16 * (v.s + 1) && o_sel_mux !== 4'((cyc - 1) / (v.s + 1))) sel_ok = 0;
        i_start = v.extra && (cyc == 5 || cyc == 10);
        i_abort = (cyc == v.abort_at);
        @(posedge i_clk); #1;
        cyc++;
      end
    end
    i_start = 1'b0;
    i_abort = 1'b0;
    chk({nm, "_busy_during"}, 32'(busy_ok), 32'd1);
    chk({nm, "_sel_steps"}, 32'(sel_ok), 32'd1);
    if (v.abort_at > 0) begin
      chk({nm, "_no_valid"}, 32'(got | o_valid), 32'd0);
      chk({nm, "_abort_idle"}, 32'(o_busy), 32'd0);
      chk({nm, "_abort_sel"}, 32'(o_sel_mux), 32'd0);
      chk({nm, "_abort_resp"}, 32'(o_resp), 32'(v.exp_resp));
      repeat (3) begin
        @(posedge i_clk); #1;
        if (o_valid !== 1'b0 || o_busy !== 1'b0) idle_ok = 0;
      end
      chk({nm, "_abort_stays_idle"}, 32'(idle_ok), 32'd1);
    end else begin
      chk({nm, "_valid_cycle"}, got ? 32'(cyc) : 32'hFFFF_FFFF, 32'(v.exp_cyc));
      chk({nm, "_resp"}, 32'(o_resp), 32'(v.exp_resp));
      chk({nm, "_busy_done"}, 32'(o_busy), 32'd1);
      chk({nm, "_sel_done"}, 32'(o_sel_mux), 32'd0);
      @(posedge i_clk); #1;
      chk({nm, "_after_done"}, {30'd0, o_valid, o_busy}, 32'd0);
      if (v.extra) begin
        repeat (20) begin
          @(posedge i_clk); #1;
          if (o_valid !== 1'b0 || o_busy !== 1'b0) idle_ok = 0;
        end
        chk({nm, "_single_valid"}, 32'(idle_ok), 32'd1);
      end
    end
  endtask

  initial begin
    vec_t v;
    int k;
    total = 0;
    bad = 0;
    //           word      S  abort extra exp_resp  exp_cyc
    tbl[0] = '{16'hA5C3, 0,  0,  0, 16'hA5C3, 17};
    tbl[1] = '{16'hA5C3, 3,  0,  0, 16'hA5C3, 65};
    tbl[2] = '{16'h0F0F, 3, 20,  0, 16'hA5C3,  0};
    tbl[3] = '{16'h3C96, 0,  0,  1, 16'h3C96, 17};
    tbl[4] = '{16'hFFFF, 1,  0,  0, 16'hFFFF, 33};
    tbl[5] = '{16'h0000, 5,  0,  0, 16'h0000, 97};
    tbl[6] = '{16'h1234, 0,  5,  0, 16'h0000,  0};
    tbl[7] = '{16'hFFFF, 0, 16,  0, 16'h0000,  0};
    tbl[8] = '{16'h8001, 2,  0,  0, 16'h8001, 49};

    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_abort = 1'b0;
    i_settle_cyc = 8'd0;
    mux_word = 16'h0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset_resp", 32'(o_resp), 32'd0);
    chk("reset_sel", 32'(o_sel_mux), 32'd0);
    chk("reset_flags", {30'd0, o_valid, o_busy}, 32'd0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Start together with abort in idle must be refused.
    i_start = 1'b1;
    i_abort = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_abort = 1'b0;
    chk("start_abort_idle", 32'(o_busy), 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_sweep(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of slot 7 clears everything immediately.
    mux_word = 16'h5A5A;
    i_settle_cyc = 8'd1;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    k = 0;
    while (o_sel_mux !== 4'd7 && k < 200) begin
      @(posedge i_clk); #1;
      k++;
    end
    chk("rst_reach_slot7", 32'(o_sel_mux), 32'd7);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("rst_mid_resp", 32'(o_resp), 32'd0);
    chk("rst_mid_sel", 32'(o_sel_mux), 32'd0);
    chk("rst_mid_flags", {30'd0, o_valid, o_busy}, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    v = '{16'hC33C, 2, 0, 0, 16'hC33C, 49};
    run_sweep(v, "post_rst");
    last_resp = 16'hC33C;

    // Random sweeps; the model only tracks which word was last published.
    for (int i = 0; i < 100; i++) begin
      v.word  = 16'($urandom);
      v.s     = $urandom_range(0, 5);
      v.extra = 0;
      v.abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 16 * (v.s + 1)) : 0;
      if (v.abort_at == 0) begin
        last_resp = v.word;
        v.exp_cyc = 1 + 16 * (v.s + 1);
      end else begin
        v.exp_cyc = 0;
      end
      v.exp_resp = last_resp;
      run_sweep(v, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
